// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS controller and its memory access unit.
package mips_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_DONE  = 2'b10,
        ST_FAULT = 2'b11
    } mau_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_CONFLICT = 2'b11
    } err_code_t;

    localparam int TIMEOUT_DEFAULT = 255;

    // Opcode field values decoded by the main controller.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Counts BUSY cycles without acknowledge; tc flags the last cycle allowed before a timeout.
module wait_counter #(
    parameter int LIMIT = 255,
    parameter int WIDTH = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: turns controller read/write strobes into a stalled, acknowledged
// memory transaction and captures read data into ir/mdr; faults are sticky until reset.
module mem_access_unit
    import mips_mc_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        IorD,
    input  logic        IRWrite,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] ir,
    output logic [31:0] mdr,
    output logic        err,
    output logic [1:0]  err_code
);

    mau_state_t  state_q, state_d;
    err_code_t   err_code_q, err_code_d;

    logic [31:0] addr_q, wdata_q;
    logic        we_q, irw_q;
    logic        access;
    logic [31:0] addr;
    logic        start, cnt_en, tc;

    assign access = MemRead | MemWrite;
    assign addr   = IorD ? alu_out : pc;

    wait_counter #(.LIMIT(TIMEOUT)) u_wait_counter (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .en  (cnt_en),
        .tc  (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        stall      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        start      = 1'b0;
        cnt_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall = access;
                if (MemRead && MemWrite) begin
                    state_d    = ST_FAULT;
                    err_code_d = ERR_CONFLICT;
                end else if (access && !is_word_aligned(addr)) begin
                    state_d    = ST_FAULT;
                    err_code_d = ERR_MISALIGN;
                end else if (access) begin
                    state_d = ST_BUSY;
                    start   = 1'b1;
                end
            end
            ST_BUSY: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = we_q;
                // An acknowledge on the terminal-count cycle still completes the access.
                if (mem_ack) begin
                    state_d = ST_DONE;
                end else if (tc) begin
                    state_d    = ST_FAULT;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                stall = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: all datapath registers are reset so a reset mid-access leaves no stale request data.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            irw_q      <= 1'b0;
            ir         <= '0;
            mdr        <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            if (start) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                we_q    <= MemWrite;
                irw_q   <= IRWrite;
            end
            if (state_q == ST_BUSY && mem_ack && !we_q) begin
                mdr <= mem_rdata;
                if (irw_q) ir <= mem_rdata;
            end
            err_code_q <= err_code_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = (state_q == ST_FAULT);
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: a transaction table plus fault and reset sequences.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite, IorD, IRWrite;
    logic [31:0] pc, alu_out, wdata;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [31:0] ir, mdr;
    logic        err;
    logic [1:0]  err_code;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IorD      (IorD),
        .IRWrite   (IRWrite),
        .pc        (pc),
        .alu_out   (alu_out),
        .wdata     (wdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .ir        (ir),
        .mdr       (mdr),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, iord, irw;
        logic [31:0] pc, alu, wdata, rdata;
        int          ack_delay;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_ir, exp_mdr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; IorD = 1'b0; IRWrite = 1'b0;
        pc = '0; alu_out = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx, input logic [31:0] prev_ir,
                           input logic [31:0] prev_mdr);
        MemRead = v.rd; MemWrite = v.wr; IorD = v.iord; IRWrite = v.irw;
        pc = v.pc; alu_out = v.alu; wdata = v.wdata; mem_ack = 1'b0;
        #1;
        check($sformatf("v%0d idle stall", idx), stall, 1);
        check($sformatf("v%0d idle req", idx), mem_req, 0);
        step();
        // Scribble the sources: the request must come from the latched copies.
        pc = '1; alu_out = '1; wdata = '0; IRWrite = ~v.irw;
        for (int k = 0; k <= v.ack_delay; k++) begin
            #1;
            check($sformatf("v%0d busy%0d req", idx, k), mem_req, 1);
            check($sformatf("v%0d busy%0d stall", idx, k), stall, 1);
            check($sformatf("v%0d busy%0d addr", idx, k), mem_addr, v.exp_addr);
            check($sformatf("v%0d busy%0d we", idx, k), mem_we, v.exp_we);
            if (v.exp_we) check($sformatf("v%0d busy%0d wdata", idx, k), mem_wdata, v.wdata);
            check($sformatf("v%0d busy%0d ir hold", idx, k), ir, prev_ir);
            check($sformatf("v%0d busy%0d mdr hold", idx, k), mdr, prev_mdr);
            if (k == v.ack_delay) begin
                mem_ack = 1'b1;
                mem_rdata = v.rdata;
            end
            step();
        end
        // DONE: strobes still high and a stray ack must both be ignored.
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        #1;
        check($sformatf("v%0d done stall", idx), stall, 0);
        check($sformatf("v%0d done req", idx), mem_req, 0);
        check($sformatf("v%0d done we", idx), mem_we, 0);
        check($sformatf("v%0d done ir", idx), ir, v.exp_ir);
        check($sformatf("v%0d done mdr", idx), mdr, v.exp_mdr);
        step();
        mem_ack = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        #1;
        check($sformatf("v%0d idle2 stall", idx), stall, 0);
        check($sformatf("v%0d idle2 req", idx), mem_req, 0);
        check($sformatf("v%0d idle2 ir", idx), ir, v.exp_ir);
        check($sformatf("v%0d idle2 mdr", idx), mdr, v.exp_mdr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{rd:1, wr:0, iord:0, irw:1, pc:32'h40, alu:32'h0, wdata:32'h0,
                    rdata:32'h8C22_0004, ack_delay:3, exp_addr:32'h40, exp_we:0,
                    exp_ir:32'h8C22_0004, exp_mdr:32'h8C22_0004};
        vecs[1] = '{rd:0, wr:1, iord:1, irw:0, pc:32'h0, alu:32'h100, wdata:32'hDEAD_BEEF,
                    rdata:32'h1111_1111, ack_delay:0, exp_addr:32'h100, exp_we:1,
                    exp_ir:32'h8C22_0004, exp_mdr:32'h8C22_0004};
        vecs[2] = '{rd:1, wr:0, iord:1, irw:0, pc:32'h0, alu:32'h200, wdata:32'h0,
                    rdata:32'h1234_5678, ack_delay:1, exp_addr:32'h200, exp_we:0,
                    exp_ir:32'h8C22_0004, exp_mdr:32'h1234_5678};
        vecs[3] = '{rd:1, wr:0, iord:0, irw:1, pc:32'h44, alu:32'h0, wdata:32'h0,
                    rdata:32'hAABB_CCDD, ack_delay:0, exp_addr:32'h44, exp_we:0,
                    exp_ir:32'hAABB_CCDD, exp_mdr:32'hAABB_CCDD};
        vecs[4] = '{rd:0, wr:1, iord:1, irw:1, pc:32'h0, alu:32'h4, wdata:32'h0000_0055,
                    rdata:32'h2222_2222, ack_delay:2, exp_addr:32'h4, exp_we:1,
                    exp_ir:32'hAABB_CCDD, exp_mdr:32'hAABB_CCDD};
        vecs[5] = '{rd:1, wr:0, iord:0, irw:0, pc:32'h48, alu:32'h3, wdata:32'h0,
                    rdata:32'h0F0F_0F0F, ack_delay:0, exp_addr:32'h48, exp_we:0,
                    exp_ir:32'hAABB_CCDD, exp_mdr:32'h0F0F_0F0F};

        // Reset state
        do_reset();
        check("rst stall", stall, 0);
        check("rst req", mem_req, 0);
        check("rst we", mem_we, 0);
        check("rst err", err, 0);
        check("rst err_code", err_code, 0);
        check("rst ir", ir, 0);
        check("rst mdr", mdr, 0);

        // Back-to-back transactions without reset
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i, (i == 0) ? 32'h0 : vecs[i-1].exp_ir,
                    (i == 0) ? 32'h0 : vecs[i-1].exp_mdr);
        end

        // Misaligned data read
        MemRead = 1'b1; IorD = 1'b1; alu_out = 32'h102;
        #1;
        check("mis idle stall", stall, 1);
        check("mis idle req", mem_req, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            MemRead = 1'b0;
            mem_ack = (i == 2);
            #1;
            check($sformatf("mis c%0d req", i), mem_req, 0);
            check($sformatf("mis c%0d stall", i), stall, 1);
            check($sformatf("mis c%0d err", i), err, 1);
            check($sformatf("mis c%0d code", i), err_code, 2'b01);
        end
        do_reset();
        check("mis rst err", err, 0);
        check("mis rst code", err_code, 0);
        check("mis rst stall", stall, 0);
        check("mis rst ir", ir, 0);

        // Read/write conflict
        MemRead = 1'b1; MemWrite = 1'b1; IorD = 1'b0; pc = 32'h40;
        #1;
        check("cfl idle stall", stall, 1);
        check("cfl idle req", mem_req, 0);
        step();
        MemRead = 1'b0; MemWrite = 1'b0;
        #1;
        check("cfl err", err, 1);
        check("cfl code", err_code, 2'b11);
        check("cfl req", mem_req, 0);
        step();
        check("cfl hold stall", stall, 1);
        check("cfl hold req", mem_req, 0);
        do_reset();

        // Timeout with TIMEOUT=4 and a late ack
        MemRead = 1'b1; IorD = 1'b0; IRWrite = 1'b1; pc = 32'h80;
        step();
        for (int k = 0; k < TO; k++) begin
            check($sformatf("to busy%0d req", k), mem_req, 1);
            check($sformatf("to busy%0d err", k), err, 0);
            check($sformatf("to busy%0d addr", k), mem_addr, 32'h80);
            step();
        end
        check("to err", err, 1);
        check("to code", err_code, 2'b10);
        check("to req", mem_req, 0);
        check("to stall", stall, 1);
        mem_ack = 1'b1; mem_rdata = 32'h9999_9999; MemRead = 1'b0;
        step();
        mem_ack = 1'b0;
        #1;
        check("to late ir", ir, 0);
        check("to late mdr", mdr, 0);
        check("to late code", err_code, 2'b10);
        check("to late stall", stall, 1);
        do_reset();

        // Reset together with ack in the second BUSY cycle
        run_vec(vecs[0], 10, 32'h0, 32'h0);
        MemRead = 1'b1; IorD = 1'b0; IRWrite = 1'b1; pc = 32'h50;
        step();
        check("rma busy1 req", mem_req, 1);
        step();
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        #1;
        check("rma busy2 req", mem_req, 1);
        step();
        rst = 1'b0; mem_ack = 1'b0; MemRead = 1'b0;
        #1;
        check("rma req", mem_req, 0);
        check("rma stall", stall, 0);
        check("rma ir", ir, 0);
        check("rma mdr", mdr, 0);
        check("rma err", err, 0);
        step();
        check("rma idle req", mem_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
